// File: rtl/debounced_input_pio_pkg.sv
// Register word addresses of the debounced input port.
package debounced_input_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_RAW     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_LIMIT   = 3'd6;

endpackage

// File: rtl/debounced_input_pio_cell.sv
// One input channel: two-flop synchroniser, run-length debounce counter and
// debounced state flop. rise/fall are single-cycle pulses on the state update.
module input_debounce_cell #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_async,
    input  logic [CNT_W-1:0] limit,
    output logic             sync,
    output logic             state,
    output logic             rise,
    output logic             fall
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             differ;
    logic             expire;

    assign differ = (sync2_reg != state_reg);
    // >= rather than == so a limit lowered below the running count fires at once
    assign expire = differ && (cnt_reg >= limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= in_async;
            sync2_reg <= sync1_reg;
            if (!differ) begin
                cnt_reg <= '0;
            end else if (expire) begin
                state_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sync  = sync2_reg;
    assign state = state_reg;
    assign rise  = expire & sync2_reg;
    assign fall  = expire & ~sync2_reg;

endmodule

// File: rtl/debounced_input_pio.sv
// Avalon-MM input port: per-channel debounce cells, sticky W1C edge capture,
// registered read mux and a level interrupt.
module debounced_input_pio
    import debounced_input_pio_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int CNT_W      = 16,
    parameter int DB_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] clr;
    logic [CNT_W-1:0] limit_reg;
    logic [31:0]      readdata_reg;
    logic [31:0]      readdata_next;
    logic             wr;
    logic             unused_writedata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            input_debounce_cell #(.CNT_W(CNT_W)) u_cell (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_async (in_port[gi]),
                .limit    (limit_reg),
                .sync     (sync[gi]),
                .state    (state[gi]),
                .rise     (rise[gi]),
                .fall     (fall[gi])
            );
        end
    endgenerate

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
    // Set terms are OR-ed after the clear so a simultaneous edge is never lost
    assign cap_next = (cap_reg & ~clr) | (rise & rise_en_reg) | (fall & fall_en_reg);

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA:    readdata_next[WIDTH-1:0] = state;
            ADDR_RAW:     readdata_next[WIDTH-1:0] = sync;
            ADDR_MASK:    readdata_next[WIDTH-1:0] = mask_reg;
            ADDR_CAPTURE: readdata_next[WIDTH-1:0] = cap_reg;
            ADDR_RISE_EN: readdata_next[WIDTH-1:0] = rise_en_reg;
            ADDR_FALL_EN: readdata_next[WIDTH-1:0] = fall_en_reg;
            ADDR_LIMIT:   readdata_next[CNT_W-1:0] = limit_reg;
            default:      readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg     <= '0;
            cap_reg      <= '0;
            rise_en_reg  <= '1;
            fall_en_reg  <= '0;
            limit_reg    <= CNT_W'(DB_DEFAULT);
            readdata_reg <= '0;
        end else begin
            cap_reg      <= cap_next;
            readdata_reg <= readdata_next;
            if (wr && address == ADDR_MASK)    mask_reg    <= writedata[WIDTH-1:0];
            if (wr && address == ADDR_RISE_EN) rise_en_reg <= writedata[WIDTH-1:0];
            if (wr && address == ADDR_FALL_EN) fall_en_reg <= writedata[WIDTH-1:0];
            if (wr && address == ADDR_LIMIT)   limit_reg   <= writedata[CNT_W-1:0];
        end
    end

    // Upper write-data bits are architecturally ignored
    assign unused_writedata = ^writedata;

    assign readdata = readdata_reg;
    assign irq      = |(cap_reg & mask_reg);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Randomised and directed checks of debounced_input_pio against a sample-history reference model.
module tb_debounced_input_pio;
    import debounced_input_pio_pkg::*;

    localparam int W = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          reset8_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [31:0]   readdata8;
    logic [W-1:0]  in_port;
    logic [7:0]    in8;
    logic          irq;
    logic          irq8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: debounced level changes once the last L+1 synchronised
    // samples all disagree with it; synchroniser is a two-sample delay line.
    logic [W-1:0]  m_state, m_cap, m_mask, m_rise_en, m_fall_en;
    logic [W-1:0]  m_dly [2];
    int            m_limit;
    logic [31:0]   m_rd;
    logic          m_irq;
    bit            hist [W][$];

    debounced_input_pio #(.WIDTH(W), .CNT_W(16), .DB_DEFAULT(1000)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    debounced_input_pio #(.WIDTH(8), .CNT_W(16), .DB_DEFAULT(0)) dut8 (
        .clk(clk), .reset_n(reset8_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata8),
        .in_port(in8), .irq(irq8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = '0;
        m_cap     = '0;
        m_mask    = '0;
        m_rise_en = '1;
        m_fall_en = '0;
        m_limit   = 1000;
        m_dly[0]  = '0;
        m_dly[1]  = '0;
        for (int i = 0; i < W; i++) hist[i].delete();
    endtask

    function automatic bit run_done(input int ch);
        int n;
        n = hist[ch].size();
        if (n < m_limit + 1) return 1'b0;
        for (int k = 0; k <= m_limit; k++)
            if (hist[ch][n-1-k] == m_state[ch]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance model by one clock edge using the currently driven inputs, then compare.
    task automatic tick();
        logic [W-1:0] s, rise, fall, clr;
        logic         wr;
        if (!reset_n) begin
            @(posedge clk); #1;
            check("rst_rd", readdata, 32'd0);
            check("rst_irq", {31'd0, irq}, 32'd0);
            return;
        end
        s  = m_dly[1];
        wr = chipselect && !write_n;
        case (address)
            ADDR_DATA:    m_rd = 32'(m_state);
            ADDR_RAW:     m_rd = 32'(s);
            ADDR_MASK:    m_rd = 32'(m_mask);
            ADDR_CAPTURE: m_rd = 32'(m_cap);
            ADDR_RISE_EN: m_rd = 32'(m_rise_en);
            ADDR_FALL_EN: m_rd = 32'(m_fall_en);
            ADDR_LIMIT:   m_rd = 32'(m_limit);
            default:      m_rd = 32'd0;
        endcase
        rise = '0;
        fall = '0;
        for (int i = 0; i < W; i++) begin
            hist[i].push_back(s[i]);
            if (hist[i].size() > 256) void'(hist[i].pop_front());
            if (run_done(i)) begin
                m_state[i] = s[i];
                if (s[i]) rise[i] = 1'b1;
                else      fall[i] = 1'b1;
            end
        end
        clr   = (wr && address == ADDR_CAPTURE) ? writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | (rise & m_rise_en) | (fall & m_fall_en);
        if (wr && address == ADDR_MASK)    m_mask    = writedata[W-1:0];
        if (wr && address == ADDR_RISE_EN) m_rise_en = writedata[W-1:0];
        if (wr && address == ADDR_FALL_EN) m_fall_en = writedata[W-1:0];
        if (wr && address == ADDR_LIMIT)   m_limit   = int'(writedata[15:0]);
        m_dly[1] = m_dly[0];
        m_dly[0] = in_port;
        m_irq    = |(m_cap & m_mask);
        @(posedge clk); #1;
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[TB] wr addr=%0d data=%h", a, d);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        d = readdata;
        $display("[TB] rd addr=%0d data=%h", a, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_rst [8];
        exp_rst[0] = 32'd0; exp_rst[1] = 32'd0; exp_rst[2] = 32'd0; exp_rst[3] = 32'd0;
        exp_rst[4] = 32'd7; exp_rst[5] = 32'd0; exp_rst[6] = 32'd1000; exp_rst[7] = 32'd0;

        reset_n = 1'b0; reset8_n = 1'b0;
        in_port = '0; in8 = '0;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1; reset8_n = 1'b1;

        // Reset values of every register
        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a), d);
            check($sformatf("reset_reg%0d", a), d, exp_rst[a]);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Short pulse rejected, long one accepted with exact latency
        wr_reg(ADDR_LIMIT, 32'd4);
        in_port[0] = 1'b1;
        repeat (4) tick();
        in_port[0] = 1'b0;
        address = ADDR_DATA;
        repeat (10) tick();
        check("glitch_data", readdata, 32'd0);
        rd_reg(ADDR_CAPTURE, d);
        check("glitch_cap", d, 32'd0);
        wr_reg(ADDR_MASK, 32'd1);
        in_port[0] = 1'b1;
        address = ADDR_DATA;
        repeat (6) tick();
        check("lat_irq_early", {31'd0, irq}, 32'd0);
        tick();
        check("lat_irq_on", {31'd0, irq}, 32'd1);
        check("lat_data_pre", readdata, 32'd0);
        tick();
        check("lat_data_post", readdata, 32'd1);

        // Falling-edge capture and write-1-to-clear
        wr_reg(ADDR_RISE_EN, 32'd0);
        wr_reg(ADDR_FALL_EN, 32'd1);
        wr_reg(ADDR_LIMIT, 32'd0);
        wr_reg(ADDR_CAPTURE, 32'hFFFF_FFFF);
        check("fall_irq_clr", {31'd0, irq}, 32'd0);
        in_port[0] = 1'b0;
        repeat (3) tick();
        check("fall_irq", {31'd0, irq}, 32'd1);
        rd_reg(ADDR_CAPTURE, d);
        check("fall_cap", d, 32'd1);
        wr_reg(ADDR_CAPTURE, 32'd0);
        rd_reg(ADDR_CAPTURE, d);
        check("w0_keeps", d, 32'd1);
        wr_reg(ADDR_CAPTURE, 32'd1);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        rd_reg(ADDR_CAPTURE, d);
        check("w1c_cap", d, 32'd0);

        // Set beats clear on the same edge
        wr_reg(ADDR_RISE_EN, 32'd7);
        wr_reg(ADDR_FALL_EN, 32'd0);
        in_port[1] = 1'b1;
        repeat (3) tick();
        rd_reg(ADDR_CAPTURE, d);
        check("bit1_set", d, 32'd2);
        in_port[1] = 1'b0;
        repeat (4) tick();
        in_port[1] = 1'b1;
        repeat (2) tick();
        wr_reg(ADDR_CAPTURE, 32'd2);
        rd_reg(ADDR_CAPTURE, d);
        check("set_beats_clr", d, 32'd2);

        // Lowering LIMIT below the running count releases the state next cycle
        wr_reg(ADDR_LIMIT, 32'd100);
        in_port[2] = 1'b1;
        repeat (50) tick();
        wr_reg(ADDR_LIMIT, 32'd10);
        address = ADDR_DATA;
        tick();
        check("limit_drop_pre", {31'd0, readdata[2]}, 32'd0);
        tick();
        check("limit_drop_post", {31'd0, readdata[2]}, 32'd1);

        // Eight-channel instance: async reset mid-toggle, then held-high inputs
        for (int i = 0; i < 20; i++) begin
            in8 = 8'($urandom());
            tick();
        end
        #2;
        reset8_n = 1'b0;
        #1;
        check("w8_rst_rd", readdata8, 32'd0);
        check("w8_rst_irq", {31'd0, irq8}, 32'd0);
        address = ADDR_DATA;
        tick();
        check("w8_rst_data", readdata8, 32'd0);
        in8 = 8'hFF;
        #2;
        reset8_n = 1'b1;
        address = ADDR_CAPTURE;
        repeat (3) tick();
        check("w8_cap_pre", readdata8, 32'd0);
        tick();
        check("w8_cap_ff", readdata8, 32'hFF);

        // Random traffic against the model, with one async reset in the middle
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 9) == 0) in_port[i] = ~in_port[i];
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom();
            if (address == ADDR_LIMIT) writedata[15:0] = 16'($urandom_range(0, 6));
            if (it == 700) begin
                #2;
                reset_n = 1'b0;
                model_reset();
                repeat (2) tick();
                #2;
                reset_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
